ace_snoop_responder: RTL



---
 rtl/ace_pkg.sv | 45 ++++
 rtl/ccu_pkg.sv | 24 ++
 rtl/ace_snoop_resp_decoder.sv | 65 ++++++
 rtl/ace_snoop_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ace_pkg.sv
// ACE snoop channel types shared by snoop requesters and responders.
package ace_pkg;

  localparam int unsigned AceAddrWidth = 64;
  localparam int unsigned AceDataWidth = 64;

  typedef logic [3:0] acsnoop_t;

  localparam acsnoop_t SnpReadOnce           = 4'b0000;
  localparam acsnoop_t SnpReadShared         = 4'b0001;
  localparam acsnoop_t SnpReadClean          = 4'b0010;
  localparam acsnoop_t SnpReadNotSharedDirty = 4'b0011;
  localparam acsnoop_t SnpReadUnique         = 4'b0111;
  localparam acsnoop_t SnpCleanShared        = 4'b1000;
  localparam acsnoop_t SnpCleanInvalid       = 4'b1001;
  localparam acsnoop_t SnpMakeInvalid        = 4'b1101;

  typedef logic [4:0] crresp_t;

  typedef struct packed {
    logic [AceAddrWidth-1:0] addr;
    acsnoop_t                snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [AceDataWidth-1:0] data;
    logic                    last;
  } cd_chan_t;

  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cr_ready;
    logic     cd_ready;
  } ace_snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    crresp_t  cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } ace_snoop_resp_t;

endpackage

// File: rtl/ccu_pkg.sv
// Coherence types: cache line states, CR bit positions and the snoop decision record.
package ccu_pkg;

  typedef enum logic {
    INVALID      = 1'b0,
    SHARED_CLEAN = 1'b1
  } cache_state_t;

  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  typedef struct packed {
    logic         dt;
    logic         pd;
    logic         is_shared;
    logic         was_unique;
    logic         do_update;
    cache_state_t new_state;
  } snoop_decision_t;

endpackage

// File: rtl/ace_snoop_resp_decoder.sv
// Maps a snoop type plus the looked-up line state to the CR fields and the state change.
module ace_snoop_resp_decoder
  import ace_pkg::*;
  import ccu_pkg::*;
(
  input  acsnoop_t        acsnoop_i,
  input  logic            hit_i,
  input  logic            dirty_i,
  input  logic            shared_i,
  output snoop_decision_t decision_o
);

  // Misses and unknown snoop types answer with an all-zero response and leave the line alone
  always_comb begin
    decision_o           = '0;
    decision_o.new_state = INVALID;
    if (hit_i) begin
      case (acsnoop_i)
        SnpReadOnce: begin
          decision_o.dt         = 1'b1;
          decision_o.is_shared  = 1'b1;
          decision_o.was_unique = !shared_i;
        end
        SnpReadShared, SnpReadClean, SnpReadNotSharedDirty: begin
          decision_o.dt         = 1'b1;
          decision_o.is_shared  = 1'b1;
          decision_o.pd         = dirty_i;
          decision_o.was_unique = !shared_i;
          decision_o.do_update  = 1'b1;
          decision_o.new_state  = SHARED_CLEAN;
        end
        SnpReadUnique: begin
          decision_o.dt         = 1'b1;
          decision_o.pd         = dirty_i;
          decision_o.was_unique = !shared_i;
          decision_o.do_update  = 1'b1;
          decision_o.new_state  = INVALID;
        end
        SnpCleanInvalid: begin
          decision_o.dt         = dirty_i;
          decision_o.pd         = dirty_i;
          decision_o.was_unique = !shared_i;
          decision_o.do_update  = 1'b1;
          decision_o.new_state  = INVALID;
        end
        SnpCleanShared: begin
          // A clean line is already in the right state, so only dirty lines get rewritten
          decision_o.dt         = dirty_i;
          decision_o.pd         = dirty_i;
          decision_o.is_shared  = 1'b1;
          decision_o.was_unique = !shared_i;
          decision_o.do_update  = dirty_i;
          decision_o.new_state  = SHARED_CLEAN;
        end
        SnpMakeInvalid: begin
          decision_o.was_unique = !shared_i;
          decision_o.do_update  = 1'b1;
          decision_o.new_state  = INVALID;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: one AC request at a time, cache lookup, state update,
// CR response and optional CD line transfer.
module ace_snoop_responder
  import ace_pkg::*;
  import ccu_pkg::*;
#(
  parameter int unsigned DcacheLineWidth = 128,
  parameter int unsigned AxiDataWidth    = 64,
  parameter int unsigned AxiAddrWidth    = 64,
  parameter type         snoop_req_t     = ace_pkg::ace_snoop_req_t,
  parameter type         snoop_resp_t    = ace_pkg::ace_snoop_resp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  snoop_req_t                 snoop_req_i,
  output snoop_resp_t                snoop_resp_o,
  output logic                       lookup_req_o,
  output logic [AxiAddrWidth-1:0]    lookup_addr_o,
  input  logic                       lookup_gnt_i,
  input  logic                       lookup_valid_i,
  input  logic                       hit_i,
  input  logic                       dirty_i,
  input  logic                       shared_i,
  input  logic [DcacheLineWidth-1:0] line_i,
  output logic                       update_valid_o,
  output cache_state_t               update_state_o,
  input  logic                       update_ready_i
);

  localparam int unsigned Beats   = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned BeatW   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned OffW    = $clog2(DcacheLineWidth / 8);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  typedef enum logic [2:0] {StIdle, StLookup, StWait, StUpdate, StResp} state_e;

  state_e                                r_state;
  state_e                                w_state_next;
  logic                                  r_ac_ready;
  logic [AxiAddrWidth-1:0]               r_addr;
  acsnoop_t                              r_snoop;
  logic [DcacheLineWidth-1:0]            r_line;
  snoop_decision_t                       r_decision;
  logic                                  r_cr_done;
  logic                                  r_cd_done;
  logic [BeatW-1:0]                      r_beat;

  snoop_decision_t                       w_decision;
  logic [AxiAddrWidth-1:0]               w_addr_aligned;
  logic [Beats-1:0][AxiDataWidth-1:0]    w_line_beats;
  crresp_t                               w_cr_resp;
  logic                                  w_ac_fire;
  logic                                  w_cr_valid;
  logic                                  w_cd_valid;
  logic                                  w_cr_fire;
  logic                                  w_cd_fire;
  logic                                  w_cd_last;
  logic                                  w_cr_complete;
  logic                                  w_cd_complete;
  logic                                  w_unused_offset;

  ace_snoop_resp_decoder u_decoder (
    .acsnoop_i  (r_snoop),
    .hit_i      (hit_i),
    .dirty_i    (dirty_i),
    .shared_i   (shared_i),
    .decision_o (w_decision)
  );

  assign w_addr_aligned  = {snoop_req_i.ac.addr[AxiAddrWidth-1:OffW], {OffW{1'b0}}};
  assign w_unused_offset = ^snoop_req_i.ac.addr[OffW-1:0];
  assign w_line_beats    = r_line;

  assign w_ac_fire  = snoop_req_i.ac_valid && r_ac_ready;
  assign w_cr_valid = (r_state == StResp) && !r_cr_done;
  assign w_cd_valid = (r_state == StResp) && r_decision.dt && !r_cd_done;
  assign w_cr_fire  = w_cr_valid && snoop_req_i.cr_ready;
  assign w_cd_fire  = w_cd_valid && snoop_req_i.cd_ready;
  assign w_cd_last  = (r_beat == LastBeat);

  // Each channel counts as finished once its final handshake is seen, in any order
  assign w_cr_complete = r_cr_done || w_cr_fire;
  assign w_cd_complete = !r_decision.dt || r_cd_done || (w_cd_fire && w_cd_last);

  // CR response word assembled from the latched decision
  always_comb begin
    w_cr_resp                 = '0;
    w_cr_resp[CrDataTransfer] = r_decision.dt;
    w_cr_resp[CrError]        = 1'b0;
    w_cr_resp[CrPassDirty]    = r_decision.pd;
    w_cr_resp[CrIsShared]     = r_decision.is_shared;
    w_cr_resp[CrWasUnique]    = r_decision.was_unique;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and cache-side handshake outputs
  always_comb begin
    w_state_next   = r_state;
    lookup_req_o   = 1'b0;
    update_valid_o = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_ac_fire) w_state_next = StLookup;
      end
      StLookup: begin
        lookup_req_o = 1'b1;
        if (lookup_gnt_i) w_state_next = StWait;
      end
      StWait: begin
        if (lookup_valid_i) w_state_next = w_decision.do_update ? StUpdate : StResp;
      end
      StUpdate: begin
        update_valid_o = 1'b1;
        if (update_ready_i) w_state_next = StResp;
      end
      StResp: begin
        if (w_cr_complete && w_cd_complete) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign lookup_addr_o  = r_addr;
  assign update_state_o = r_decision.new_state;

  // Snoop channel outputs; CD payload only moves on a CD handshake so it stays stable
  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = r_ac_ready;
    snoop_resp_o.cr_valid = w_cr_valid;
    snoop_resp_o.cr_resp  = w_cr_resp;
    snoop_resp_o.cd_valid = w_cd_valid;
    snoop_resp_o.cd.data  = w_line_beats[r_beat];
    snoop_resp_o.cd.last  = w_cd_last;
  end

  // Request/lookup capture, channel completion flags and the CD beat counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ac_ready <= 1'b0;
      r_addr     <= '0;
      r_snoop    <= '0;
      r_line     <= '0;
      r_decision <= '0;
      r_cr_done  <= 1'b0;
      r_cd_done  <= 1'b0;
      r_beat     <= '0;
    end else begin
      r_ac_ready <= (w_state_next == StIdle);
      if (w_ac_fire) begin
        r_addr  <= w_addr_aligned;
        r_snoop <= snoop_req_i.ac.snoop;
      end
      if ((r_state == StWait) && lookup_valid_i) begin
        r_line     <= line_i;
        r_decision <= w_decision;
      end
      if (r_state == StIdle) begin
        r_cr_done <= 1'b0;
        r_cd_done <= 1'b0;
        r_beat    <= '0;
      end else begin
        if (w_cr_fire) r_cr_done <= 1'b1;
        if (w_cd_fire) begin
          r_beat <= w_cd_last ? '0 : r_beat + BeatW'(1);
          if (w_cd_last) r_cd_done <= 1'b1;
        end
      end
    end
  end

endmodule
